// File: rtl/reconf_dsp_seq.sv
// Microcode sequencer for one reconfigurable DSP element.
// Plays a small program RAM as a loop onto the exe_* control bus, stalls in
// lock-step with the element on input underflow, and drains the DSP pipe
// with NOP words after the final iteration.
module reconf_dsp_seq #(
  parameter int FIFO_PA_BITS = 5,
  parameter int FIFO_PD_BITS = 5,
  parameter int FIFO_PF_BITS = 5,
  parameter int CMD_WIDTH    = 3,
  parameter int PROG_BITS    = 5,
  parameter int DRAIN_CYCLES = 6,
  localparam int PW = FIFO_PA_BITS + FIFO_PD_BITS + FIFO_PF_BITS + CMD_WIDTH + 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_wr,
  input  logic [PROG_BITS-1:0]    cfg_addr,
  input  logic [PW-1:0]           cfg_data,
  input  logic                    cfg_omux,
  output logic                    cfg_err,
  input  logic                    start,
  input  logic                    stop,
  input  logic [15:0]             loop_num,
  output logic                    busy,
  output logic                    done,
  output logic [15:0]             iter_cnt,
  input  logic                    din_valid,
  output logic [FIFO_PA_BITS-1:0] exe_faa,
  output logic [FIFO_PD_BITS-1:0] exe_fad,
  output logic [FIFO_PF_BITS-1:0] exe_fac,
  output logic                    exe_pa_l,
  output logic                    exe_pd_l,
  output logic                    exe_pc_l,
  output logic                    exe_pi_r,
  output logic                    exe_pp_l,
  output logic [CMD_WIDTH-1:0]    exe_cmd,
  output logic                    exe_cfg_omux
);

  // Field positions inside a microcode word (faa in the LSBs).
  localparam int FD_LO  = FIFO_PA_BITS;
  localparam int FC_LO  = FD_LO + FIFO_PD_BITS;
  localparam int CMD_LO = FC_LO + FIFO_PF_BITS;
  localparam int PA_B   = CMD_LO + CMD_WIDTH;
  localparam int PD_B   = PA_B + 1;
  localparam int PC_B   = PA_B + 2;
  localparam int PI_B   = PA_B + 3;
  localparam int PP_B   = PA_B + 4;
  localparam int LAST_B = PA_B + 5;

  localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [PW-1:0]        prog_mem [1<<PROG_BITS];

  logic [1:0]           state_q,     state_d;
  logic [PROG_BITS-1:0] pc_q,        pc_d;
  logic [PW-1:0]        ir_q,        ir_d;
  logic [15:0]          iter_cnt_q,  iter_cnt_d;
  logic [15:0]          loop_num_q,  loop_num_d;
  logic                 stop_pend_q, stop_pend_d;
  logic [DCW-1:0]       drain_cnt_q, drain_cnt_d;
  logic                 done_q,      done_d;
  logic                 cfg_err_q,   cfg_err_d;
  logic                 omux_q,      omux_d;

  logic                 step;
  logic [PROG_BITS-1:0] pc_nxt;
  logic [15:0]          iter_inc;
  logic [PW-1:0]        word_out;

  // Program RAM: writable only while idle; contents survive reset.
  always_ff @(posedge clk) begin
    if (cfg_wr && (state_q == S_IDLE)) prog_mem[cfg_addr] <= cfg_data;
  end

  // Sequencer next-state: fetch, loop, stall and drain control.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    iter_cnt_d  = iter_cnt_q;
    loop_num_d  = loop_num_q;
    stop_pend_d = stop_pend_q;
    drain_cnt_d = drain_cnt_q;
    done_d      = 1'b0;
    cfg_err_d   = cfg_err_q | (cfg_wr && (state_q != S_IDLE));
    omux_d      = cfg_omux;
    // Same pipe-enable equation the element evaluates, so both stall together.
    step        = (state_q == S_RUN) && (~ir_q[PI_B] || din_valid);
    pc_nxt      = pc_q + 1'b1;
    iter_inc    = iter_cnt_q + 16'd1;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          pc_d        = '0;
          ir_d        = prog_mem[0];
          iter_cnt_d  = '0;
          loop_num_d  = loop_num;
          stop_pend_d = 1'b0;
          state_d     = S_RUN;
        end
      end
      S_RUN: begin
        if (stop) stop_pend_d = 1'b1;
        if (step) begin
          if (!ir_q[LAST_B]) begin
            pc_d = pc_nxt;
            ir_d = prog_mem[pc_nxt];
          end else begin
            iter_cnt_d = iter_inc;
            if (stop_pend_q || ((loop_num_q != 16'd0) && (iter_inc == loop_num_q))) begin
              ir_d        = '0;
              state_d     = S_DRAIN;
              stop_pend_d = 1'b0;
              drain_cnt_d = '0;
            end else begin
              // Back-to-back iterations: word 0 follows the last word directly.
              pc_d = '0;
              ir_d = prog_mem[0];
            end
          end
        end
      end
      S_DRAIN: begin
        if (drain_cnt_q == DCW'(DRAIN_CYCLES - 1)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer state registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      ir_q        <= '0;
      iter_cnt_q  <= '0;
      loop_num_q  <= '0;
      stop_pend_q <= 1'b0;
      drain_cnt_q <= '0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
      omux_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      iter_cnt_q  <= iter_cnt_d;
      loop_num_q  <= loop_num_d;
      stop_pend_q <= stop_pend_d;
      drain_cnt_q <= drain_cnt_d;
      done_q      <= done_d;
      cfg_err_q   <= cfg_err_d;
      omux_q      <= omux_d;
    end
  end

  // Outside RUN the bus carries the all-zero NOP word.
  assign word_out     = (state_q == S_RUN) ? ir_q : '0;

  assign exe_faa      = word_out[FD_LO-1:0];
  assign exe_fad      = word_out[FC_LO-1:FD_LO];
  assign exe_fac      = word_out[CMD_LO-1:FC_LO];
  assign exe_cmd      = word_out[PA_B-1:CMD_LO];
  assign exe_pa_l     = word_out[PA_B];
  assign exe_pd_l     = word_out[PD_B];
  assign exe_pc_l     = word_out[PC_B];
  assign exe_pi_r     = word_out[PI_B];
  assign exe_pp_l     = word_out[PP_B];
  assign exe_cfg_omux = omux_q;

  assign busy         = (state_q != S_IDLE);
  assign done         = done_q;
  assign iter_cnt     = iter_cnt_q;
  assign cfg_err      = cfg_err_q;

endmodule

// File: tb/tb_reconf_dsp_seq.sv
// Scoreboard bench for reconf_dsp_seq: stimulus pushes the expected bus
// trace, a negedge monitor pops and compares whenever the sequencer is busy
// or signalling done.
module tb_reconf_dsp_seq;

  logic        clk, rst;
  logic        cfg_wr, cfg_omux, cfg_err;
  logic [4:0]  cfg_addr;
  logic [23:0] cfg_data;
  logic        start, stop, busy, done, din_valid;
  logic [15:0] loop_num, iter_cnt;
  logic [4:0]  exe_faa, exe_fad, exe_fac;
  logic        exe_pa_l, exe_pd_l, exe_pc_l, exe_pi_r, exe_pp_l, exe_cfg_omux;
  logic [2:0]  exe_cmd;

  reconf_dsp_seq dut (
    .clk(clk), .rst(rst),
    .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_omux(cfg_omux), .cfg_err(cfg_err),
    .start(start), .stop(stop), .loop_num(loop_num),
    .busy(busy), .done(done), .iter_cnt(iter_cnt), .din_valid(din_valid),
    .exe_faa(exe_faa), .exe_fad(exe_fad), .exe_fac(exe_fac),
    .exe_pa_l(exe_pa_l), .exe_pd_l(exe_pd_l), .exe_pc_l(exe_pc_l),
    .exe_pi_r(exe_pi_r), .exe_pp_l(exe_pp_l), .exe_cmd(exe_cmd),
    .exe_cfg_omux(exe_cfg_omux)
  );

  typedef struct packed {
    logic [22:0] word;
    logic        busy;
    logic        done;
    logic [15:0] iter;
  } rec_t;

  rec_t        exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [23:0] prog_w [3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [22:0] bus_word();
    return {exe_pp_l, exe_pi_r, exe_pc_l, exe_pd_l, exe_pa_l,
            exe_cmd, exe_fac, exe_fad, exe_faa};
  endfunction

  // Monitor: one expected record per cycle the sequencer presents output.
  always @(negedge clk) begin
    rec_t got, e;
    if (!rst && (busy || done)) begin
      got = '{word: bus_word(), busy: busy, done: done, iter: iter_cnt};
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_output: got word=%h busy=%b done=%b iter=%0d, required none",
                 got.word, got.busy, got.done, got.iter);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          n_err++;
          $display("FAIL exe_trace: got word=%h busy=%b done=%b iter=%0d, required word=%h busy=%b done=%b iter=%0d",
                   got.word, got.busy, got.done, got.iter, e.word, e.busy, e.done, e.iter);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    n_vec++;
    if (got !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [23:0] w, input logic b, input logic d, input int it);
    exp_q.push_back('{word: w[22:0], busy: b, done: d, iter: 16'(it)});
  endtask

  // Expected trace for prog_w[0..2] looped 'loops' times, then drain and done.
  task automatic push_run(input int loops);
    for (int it = 0; it < loops; it++)
      for (int i = 0; i < 3; i++) push(prog_w[i], 1'b1, 1'b0, it);
    for (int k = 0; k < 6; k++) push(24'h0, 1'b1, 1'b0, loops);
    push(24'h0, 1'b0, 1'b1, loops);
  endtask

  task automatic write_word(input logic [4:0] a, input logic [23:0] d);
    cfg_wr = 1'b1; cfg_addr = a; cfg_data = d;
    tick();
    cfg_wr = 1'b0;
  endtask

  task automatic pulse_start(input logic [15:0] n);
    loop_num = n; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    tick();
    n_vec++;
    if (!seen) begin
      n_err++;
      $display("FAIL %s_timeout: got no done within 200 cycles, required done pulse", name);
    end
    check({name, "_queue_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; cfg_wr = 1'b0; cfg_addr = '0; cfg_data = '0; cfg_omux = 1'b0;
    start = 1'b0; stop = 1'b0; loop_num = '0; din_valid = 1'b1;
    prog_w[0] = 24'h0A5A21;
    prog_w[1] = 24'h151234;
    prog_w[2] = 24'h834567;
    #1 rst = 1'b1;
    #1;
    // Reset state
    check("rst_busy",    busy,       0);
    check("rst_done",    done,       0);
    check("rst_iter",    iter_cnt,   0);
    check("rst_cfg_err", cfg_err,    0);
    check("rst_exe",     bus_word(), 0);
    check("rst_omux",    exe_cfg_omux, 0);
    tick();
    rst = 1'b0;
    cfg_omux = 1'b1;
    tick();
    check("omux_follow_1", exe_cfg_omux, 1);
    cfg_omux = 1'b0;
    tick();
    check("omux_follow_0", exe_cfg_omux, 0);

    for (int i = 0; i < 3; i++) write_word(5'(i), prog_w[i]);

    // Three-word loop, four iterations
    push_run(4);
    pulse_start(16'd4);
    wait_done("loop4");
    check("loop4_iter", iter_cnt, 4);

    // Free-running loop stopped during iteration 3 (word 1 on the bus)
    push_run(3);
    pulse_start(16'd0);
    repeat (7) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    wait_done("stop");
    check("stop_iter", iter_cnt, 3);

    // start and stop together in IDLE: start wins
    push_run(2);
    stop = 1'b1;
    pulse_start(16'd2);
    stop = 1'b0;
    wait_done("start_stop");
    check("start_stop_iter", iter_cnt, 2);

    // Write while busy is dropped and flags cfg_err
    push_run(1);
    pulse_start(16'd1);
    write_word(5'd0, 24'hFFFFFF);
    wait_done("busy_wr");
    check("busy_wr_err", cfg_err, 1);
    write_word(5'd5, 24'h123456);
    check("idle_wr_err_kept", cfg_err, 1);
    push_run(1);
    pulse_start(16'd1);
    wait_done("readback");

    // Async reset while word 1 is on the bus
    cfg_omux = 1'b1;
    push(prog_w[0], 1'b1, 1'b0, 0);
    pulse_start(16'd0);
    tick();
    check("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("midrst_exe",     bus_word(), 0);
    check("midrst_busy",    busy,       0);
    check("midrst_cfg_err", cfg_err,    0);
    check("midrst_omux",    exe_cfg_omux, 0);
    #1 rst = 1'b0;
    tick();
    check("postrst_omux", exe_cfg_omux, 1);
    check("postrst_queue_empty", exp_q.size(), 0);
    push_run(1);
    pulse_start(16'd1);
    wait_done("restart");
    check("restart_iter", iter_cnt, 1);

    // Stall on word 1 (pi_r=1) while din_valid is low for 5 cycles
    prog_w[0] = 24'h012345;
    prog_w[1] = 24'h200111;
    prog_w[2] = 24'h800222;
    for (int i = 0; i < 3; i++) write_word(5'(i), prog_w[i]);
    din_valid = 1'b0;
    push(prog_w[0], 1'b1, 1'b0, 0);
    for (int k = 0; k < 6; k++) push(prog_w[1], 1'b1, 1'b0, 0);
    push(prog_w[2], 1'b1, 1'b0, 0);
    for (int k = 0; k < 6; k++) push(24'h0, 1'b1, 1'b0, 1);
    push(24'h0, 1'b0, 1'b1, 1);
    pulse_start(16'd1);
    repeat (6) tick();
    din_valid = 1'b1;
    wait_done("stall");
    check("stall_iter", iter_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
